// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : 5-stage pipeline sequencer: memory freeze, branch redirect,
//            load-use stall and halt, with saturating stall/flush counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
   parameter int BR_PENALTY = 1,
   parameter int CNT_W      = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mem_busy,
   input  logic             br_taken,
   input  logic [31:0]      br_target,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rd,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             halt_req,
   output logic             pc_we,
   output logic             redirect,
   output logic [31:0]      redirect_pc,
   output logic             ifid_we,
   output logic             ifid_flush,
   output logic             idex_we,
   output logic             idex_flush,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] flush_events
);

   typedef enum logic [2:0] {
      S_PRIME = 3'd0,
      S_RUN   = 3'd1,
      S_STALL = 3'd2,
      S_FLUSH = 3'd3,
      S_HALT  = 3'd4
   } state_t;

   localparam logic [2:0] PENALTY = 3'(BR_PENALTY);

   state_t           state_q, state_d;
   logic [2:0]       fl_cnt_q, fl_cnt_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;
   logic             load_use;
   logic             count_stall;

   assign load_use = ex_memread && (ex_rd != 5'd0) &&
                     ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

   assign redirect_pc  = br_target;
   assign state        = state_q;
   assign stall_cycles = stall_q;
   assign flush_events = flush_q;

   always_comb begin
      pc_we       = 1'b1;
      redirect    = 1'b0;
      ifid_we     = 1'b1;
      ifid_flush  = 1'b0;
      idex_we     = 1'b1;
      idex_flush  = 1'b0;
      state_d     = state_q;
      fl_cnt_d    = fl_cnt_q;
      stall_d     = stall_q;
      flush_d     = flush_q;
      count_stall = 1'b0;
      if (rst) begin
         pc_we      = 1'b0;
         ifid_we    = 1'b0;
         idex_we    = 1'b0;
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
         state_d    = S_PRIME;
         fl_cnt_d   = 3'd0;
         stall_d    = '0;
         flush_d    = '0;
      end else begin
         case (state_q)
            S_PRIME: begin
               pc_we      = 1'b0;
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               state_d    = S_RUN;
            end
            // STALL with mem_busy low behaves as a RUN cycle without item 1
            S_RUN, S_STALL: begin
               if (mem_busy) begin
                  pc_we       = 1'b0;
                  ifid_we     = 1'b0;
                  idex_we     = 1'b0;
                  count_stall = 1'b1;
                  state_d     = S_STALL;
               end else if (br_taken) begin
                  redirect   = 1'b1;
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
                  fl_cnt_d   = PENALTY;
                  state_d    = (PENALTY != 3'd0) ? S_FLUSH : S_RUN;
                  if (flush_q != '1) flush_d = flush_q + 1'b1;
               end else if (load_use) begin
                  pc_we       = 1'b0;
                  ifid_we     = 1'b0;
                  idex_flush  = 1'b1;
                  count_stall = 1'b1;
                  state_d     = S_RUN;
               end else if (halt_req) begin
                  pc_we       = 1'b0;
                  ifid_we     = 1'b0;
                  idex_flush  = 1'b1;
                  count_stall = 1'b1;
                  state_d     = S_HALT;
               end else begin
                  state_d = S_RUN;
               end
            end
            S_FLUSH: begin
               if (mem_busy) begin
                  pc_we   = 1'b0;
                  ifid_we = 1'b0;
                  idex_we = 1'b0;
               end else begin
                  ifid_flush = 1'b1;
                  if (fl_cnt_q <= 3'd1) state_d = S_RUN;
                  else fl_cnt_d = fl_cnt_q - 3'd1;
               end
            end
            S_HALT: begin
               pc_we      = 1'b0;
               ifid_we    = 1'b0;
               idex_flush = 1'b1;
            end
            default: begin
               state_d = S_PRIME;
            end
         endcase
         if (count_stall && (stall_q != '1)) stall_d = stall_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_PRIME;
         fl_cnt_q <= 3'd0;
         stall_q  <= '0;
         flush_q  <= '0;
      end else begin
         state_q  <= state_d;
         fl_cnt_q <= fl_cnt_d;
         stall_q  <= stall_d;
         flush_q  <= flush_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Self-checking bench: directed vector table, corner sequences,
//            randomized run against a reference model, counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

   localparam int BRP = 1;
   localparam int CW  = 16;

   localparam logic [5:0] C_RST = 6'b000101;
   localparam logic [5:0] C_PRI = 6'b001111;
   localparam logic [5:0] C_DEF = 6'b101010;
   localparam logic [5:0] C_LU  = 6'b000011;
   localparam logic [5:0] C_BR  = 6'b111111;
   localparam logic [5:0] C_FL  = 6'b101110;
   localparam logic [5:0] C_FRZ = 6'b000000;
   localparam logic [5:0] C_HLT = 6'b000011;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst, mem_busy, br_taken, ex_memread, id_uses_rt, halt_req;
   logic [31:0]   br_target;
   logic [4:0]    ex_rd, id_rs, id_rt;
   logic          pc_we, redirect, ifid_we, ifid_flush, idex_we, idex_flush;
   logic [31:0]   redirect_pc;
   logic [2:0]    state;
   logic [CW-1:0] stall_cycles, flush_events;
   logic [5:0]    ctl;

   assign ctl = {pc_we, redirect, ifid_we, ifid_flush, idex_we, idex_flush};

   pipe_hazard_ctrl #(.BR_PENALTY(BRP), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .mem_busy(mem_busy), .br_taken(br_taken),
      .br_target(br_target), .ex_memread(ex_memread), .ex_rd(ex_rd),
      .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .halt_req(halt_req), .pc_we(pc_we), .redirect(redirect),
      .redirect_pc(redirect_pc), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
      .idex_we(idex_we), .idex_flush(idex_flush), .state(state),
      .stall_cycles(stall_cycles), .flush_events(flush_events)
   );

   typedef struct {
      logic        mb, br;
      logic [31:0] tgt;
      logic        mr;
      logic [4:0]  exrd, rs, rt;
      logic        urt, halt;
      logic [5:0]  ctl;
      logic [2:0]  st;
      logic [15:0] sc, fe;
   } vec_t;

   vec_t tbl[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: architectural mode plus remaining flush bubbles
   int         m_mode, m_fl, m_sc, m_fe;
   int         n_mode, n_fl, n_sc, n_fe;
   logic [5:0] e_ctl;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic addv(input logic mb, input logic br, input logic [31:0] tgt,
                       input logic mr, input logic [4:0] exrd, input logic [4:0] rs,
                       input logic [4:0] rt, input logic urt, input logic halt,
                       input logic [5:0] c, input logic [2:0] st,
                       input logic [15:0] sc, input logic [15:0] fe);
      vec_t v;
      v.mb = mb; v.br = br; v.tgt = tgt; v.mr = mr; v.exrd = exrd; v.rs = rs;
      v.rt = rt; v.urt = urt; v.halt = halt; v.ctl = c; v.st = st; v.sc = sc; v.fe = fe;
      tbl.push_back(v);
   endtask

   task automatic drive(input logic r, input logic mb, input logic br, input logic [31:0] tgt,
                        input logic mr, input logic [4:0] exrd, input logic [4:0] rs,
                        input logic [4:0] rt, input logic urt, input logic halt);
      rst = r; mem_busy = mb; br_taken = br; br_target = tgt; ex_memread = mr;
      ex_rd = exrd; id_rs = rs; id_rt = rt; id_uses_rt = urt; halt_req = halt;
   endtask

   task automatic idle(input logic r);
      drive(r, 0, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic int sat(input int x);
      return (x > 65535) ? 65535 : x;
   endfunction

   task automatic model_eval();
      bit lu;
      lu = ex_memread && (ex_rd != 0) &&
           ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
      n_mode = m_mode; n_fl = m_fl; n_sc = m_sc; n_fe = m_fe;
      if (rst) begin
         e_ctl = C_RST; n_mode = 0; n_fl = 0; n_sc = 0; n_fe = 0;
      end else if (m_mode == 0) begin
         e_ctl = C_PRI; n_mode = 1;
      end else if (m_mode == 4) begin
         e_ctl = C_HLT;
      end else if (mem_busy) begin
         e_ctl = C_FRZ;
         if (m_mode != 3) begin n_mode = 2; n_sc = sat(m_sc + 1); end
      end else if (m_mode == 3) begin
         e_ctl = C_FL;
         if (m_fl > 1) n_fl = m_fl - 1; else n_mode = 1;
      end else if (br_taken) begin
         e_ctl = C_BR; n_fe = sat(m_fe + 1); n_fl = BRP;
         n_mode = (BRP > 0) ? 3 : 1;
      end else if (lu) begin
         e_ctl = C_LU; n_mode = 1; n_sc = sat(m_sc + 1);
      end else if (halt_req) begin
         e_ctl = C_HLT; n_mode = 4; n_sc = sat(m_sc + 1);
      end else begin
         e_ctl = C_DEF; n_mode = 1;
      end
   endtask

   initial begin
      // mb br tgt mr exrd rs rt urt halt | ctl st sc fe
      addv(0,0,32'h0 ,0,0,0,0,0,0, C_PRI,0,0,0);
      addv(0,0,32'h0 ,0,0,0,0,0,0, C_DEF,1,0,0);
      addv(0,0,32'h0 ,1,4,4,0,0,0, C_LU ,1,0,0);
      addv(0,0,32'h0 ,0,0,0,0,0,0, C_DEF,1,1,0);
      addv(0,0,32'h0 ,1,0,0,0,0,0, C_DEF,1,1,0);
      addv(0,0,32'h0 ,1,7,3,7,1,0, C_LU ,1,1,0);
      addv(0,0,32'h0 ,1,7,3,7,0,0, C_DEF,1,2,0);
      addv(0,1,32'h4 ,0,0,0,0,0,0, C_BR ,1,2,0);
      addv(0,0,32'h0 ,0,0,0,0,0,0, C_FL ,3,2,1);
      addv(0,0,32'h0 ,0,0,0,0,0,0, C_DEF,1,2,1);
      addv(1,1,32'h8 ,0,0,0,0,0,0, C_FRZ,1,2,1);
      addv(1,1,32'h8 ,0,0,0,0,0,0, C_FRZ,2,3,1);
      addv(1,1,32'h8 ,0,0,0,0,0,0, C_FRZ,2,4,1);
      addv(0,1,32'h8 ,0,0,0,0,0,0, C_BR ,2,5,1);
      addv(0,0,32'h0 ,0,0,0,0,0,0, C_FL ,3,5,2);
      addv(0,0,32'h0 ,0,0,0,0,0,0, C_DEF,1,5,2);
      addv(0,1,32'h10,1,2,2,0,0,1, C_BR ,1,5,2);
      addv(0,0,32'h0 ,0,0,0,0,0,1, C_FL ,3,5,3);
      addv(0,0,32'h0 ,0,0,0,0,0,1, C_HLT,1,5,3);
      addv(0,0,32'h0 ,0,0,0,0,0,0, C_HLT,4,6,3);
      addv(0,1,32'h20,0,0,0,0,0,0, C_HLT,4,6,3);

      idle(1);
      next_cycle();
      @(negedge clk);
      chk("reset_ctl", 32'(ctl), 32'(C_RST));
      chk("reset_state", 32'(state), 32'd0);
      chk("reset_stall", 32'(stall_cycles), 32'd0);
      chk("reset_flush", 32'(flush_events), 32'd0);
      next_cycle();

      foreach (tbl[i]) begin
         drive(0, tbl[i].mb, tbl[i].br, tbl[i].tgt, tbl[i].mr, tbl[i].exrd,
               tbl[i].rs, tbl[i].rt, tbl[i].urt, tbl[i].halt);
         @(negedge clk);
         chk($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(tbl[i].ctl));
         chk($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].st));
         chk($sformatf("vec%0d_stall", i), 32'(stall_cycles), 32'(tbl[i].sc));
         chk($sformatf("vec%0d_flush", i), 32'(flush_events), 32'(tbl[i].fe));
         chk($sformatf("vec%0d_rpc", i), redirect_pc, tbl[i].tgt);
         next_cycle();
      end

      // Halt persists; reset leaves it
      idle(0);
      repeat (5) next_cycle();
      @(negedge clk);
      chk("halt_hold_pc", 32'(pc_we), 32'd0);
      chk("halt_hold_state", 32'(state), 32'd4);
      idle(1);
      next_cycle();
      idle(0);
      @(negedge clk);
      chk("halt_rst_state", 32'(state), 32'd0);
      chk("halt_rst_ctl", 32'(ctl), 32'(C_PRI));
      next_cycle();

      // Reset in the middle of a memory stall
      drive(0, 1, 0, 32'h0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
      repeat (2) next_cycle();
      @(negedge clk);
      chk("mid_stall_state", 32'(state), 32'd2);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_stall_rst_ctl", 32'(ctl), 32'(C_RST));
      next_cycle();
      idle(0);
      @(negedge clk);
      chk("mid_stall_rst_state", 32'(state), 32'd0);
      chk("mid_stall_rst_cnt", 32'(stall_cycles), 32'd0);

      // Randomized run against the model
      m_mode = 0; m_fl = 0; m_sc = 0; m_fe = 0;
      for (int c = 0; c < 4000; c++) begin
         drive((c == 0) || ($urandom_range(49) == 0),
               $urandom_range(3) == 0, $urandom_range(4) == 0, $urandom,
               $urandom_range(1) == 1, 5'($urandom_range(3)), 5'($urandom_range(3)),
               5'($urandom_range(3)), $urandom_range(1) == 1, $urandom_range(39) == 0);
         model_eval();
         @(negedge clk);
         chk("rnd_ctl", 32'(ctl), 32'(e_ctl));
         chk("rnd_state", 32'(state), 32'(m_mode));
         chk("rnd_stall", 32'(stall_cycles), 32'(m_sc));
         chk("rnd_flush", 32'(flush_events), 32'(m_fe));
         chk("rnd_rpc", redirect_pc, br_target);
         next_cycle();
         m_mode = n_mode; m_fl = n_fl; m_sc = n_sc; m_fe = n_fe;
      end

      // Stall counter saturation
      idle(1);
      next_cycle();
      idle(0);
      next_cycle();
      drive(0, 0, 0, 32'h0, 1, 5'd9, 5'd9, 5'd0, 0, 0);
      repeat (70000) next_cycle();
      @(negedge clk);
      chk("sat_stall", 32'(stall_cycles), 32'hFFFF);
      chk("sat_state", 32'(state), 32'd1);
      chk("sat_flush", 32'(flush_events), 32'd0);
      chk("sat_ctl", 32'(ctl), 32'(C_LU));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
